// File: rtl/flash_op_scheduler_if.sv
// Signal bundle between the flash op scheduler, its two requesters and the flash_sf3 controller.
// slave is the scheduler's view; master is the surrounding system's view.
interface flash_op_scheduler_if;
    logic        req0;
    logic [1:0]  op0;
    logic [23:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic [1:0]  op1;
    logic [23:0] addr1;
    logic [31:0] wdata1;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic        busy;
    logic        f_read_rq;
    logic [23:0] f_read_addr;
    logic        f_write_en_req;
    logic        f_write_req;
    logic [23:0] f_write_page;
    logic [31:0] f_write_data;
    logic        f_sector_erase_req;
    logic [23:0] f_sector_erase_addr;
    logic        f_read_end;
    logic        f_write_en_end;
    logic        f_write_end;
    logic        f_sector_erase_end;
    logic [31:0] f_read_data_word;

    modport slave (
        input  req0, op0, addr0, wdata0, req1, op1, addr1, wdata1,
        input  f_read_end, f_write_en_end, f_write_end, f_sector_erase_end, f_read_data_word,
        output done, err, rdata, busy,
        output f_read_rq, f_read_addr, f_write_en_req, f_write_req, f_write_page, f_write_data,
        output f_sector_erase_req, f_sector_erase_addr
    );

    modport master (
        output req0, op0, addr0, wdata0, req1, op1, addr1, wdata1,
        output f_read_end, f_write_en_end, f_write_end, f_sector_erase_end, f_read_data_word,
        input  done, err, rdata, busy,
        input  f_read_rq, f_read_addr, f_write_en_req, f_write_req, f_write_page, f_write_data,
        input  f_sector_erase_req, f_sector_erase_addr
    );
endinterface

// File: rtl/flash_op_scheduler.sv
// Two-port arbiter/sequencer in front of one flash_sf3 controller: read, program (WEN+PROG)
// and sector erase (WEN+ERASE), with per-step timeout and port-1 starvation protection.
module flash_op_scheduler #(
    parameter int TIMEOUT      = 25_000_000,
    parameter int TO_W         = 25,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 HCLK,
    input  logic                 HRST,
    flash_op_scheduler_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WEN   = 3'd2;
    localparam logic [2:0] S_PROG  = 3'd3;
    localparam logic [2:0] S_ERASE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic            r_id;
    logic [1:0]      r_op;
    logic [SW-1:0]   r_streak;
    logic [TO_W-1:0] r_cnt;
    logic [1:0]      r_done;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic            r_busy;
    logic            r_read_rq;
    logic [23:0]     r_read_addr;
    logic            r_wen_req;
    logic            r_write_req;
    logic [23:0]     r_write_page;
    logic [31:0]     r_write_data;
    logic            r_erase_req;
    logic [23:0]     r_erase_addr;

    logic            w_any;
    logic            w_grant1;
    logic [1:0]      w_op;
    logic [23:0]     w_addr;
    logic [31:0]     w_wdata;
    logic            w_timeout;
    logic [1:0]      w_done_id;

    assign w_any     = bus.req0 | bus.req1;
    assign w_grant1  = bus.req1 && (!bus.req0 || r_streak == STREAK_MAX);
    assign w_op      = w_grant1 ? bus.op1    : bus.op0;
    assign w_addr    = w_grant1 ? bus.addr1  : bus.addr0;
    assign w_wdata   = w_grant1 ? bus.wdata1 : bus.wdata0;
    assign w_timeout = (r_cnt == TO_LAST);
    assign w_done_id = r_id ? 2'b10 : 2'b01;

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            r_state      <= S_IDLE;
            r_id         <= 1'b0;
            r_op         <= 2'b00;
            r_streak     <= '0;
            r_cnt        <= '0;
            r_done       <= 2'b00;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
            r_busy       <= 1'b0;
            r_read_rq    <= 1'b0;
            r_read_addr  <= 24'd0;
            r_wen_req    <= 1'b0;
            r_write_req  <= 1'b0;
            r_write_page <= 24'd0;
            r_write_data <= 32'd0;
            r_erase_req  <= 1'b0;
            r_erase_addr <= 24'd0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id   <= w_grant1;
                        r_op   <= w_op;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        // A port-0 win only counts towards starvation while port 1 is waiting.
                        if (w_grant1 || !bus.req1)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                        case (w_op)
                            2'b00: begin
                                r_read_rq   <= 1'b1;
                                r_read_addr <= w_addr;
                                r_state     <= S_RD;
                            end
                            2'b01: begin
                                r_wen_req    <= 1'b1;
                                r_write_page <= w_addr;
                                r_write_data <= w_wdata;
                                r_state      <= S_WEN;
                            end
                            2'b10: begin
                                r_wen_req    <= 1'b1;
                                r_erase_addr <= w_addr;
                                r_state      <= S_WEN;
                            end
                            default: begin
                                r_done  <= w_grant1 ? 2'b10 : 2'b01;
                                r_err   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    if (bus.f_read_end || w_timeout) begin
                        r_read_rq <= 1'b0;
                        r_rdata   <= bus.f_read_end ? bus.f_read_data_word : 32'd0;
                        r_err     <= !bus.f_read_end;
                        r_done    <= w_done_id;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WEN: begin
                    if (bus.f_write_en_end) begin
                        r_wen_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_op == 2'b01) begin
                            r_write_req <= 1'b1;
                            r_state     <= S_PROG;
                        end else begin
                            r_erase_req <= 1'b1;
                            r_state     <= S_ERASE;
                        end
                    end else if (w_timeout) begin
                        r_wen_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_done    <= w_done_id;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PROG: begin
                    if (bus.f_write_end || w_timeout) begin
                        r_write_req <= 1'b0;
                        r_err       <= !bus.f_write_end;
                        r_done      <= w_done_id;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ERASE: begin
                    if (bus.f_sector_erase_end || w_timeout) begin
                        r_erase_req <= 1'b0;
                        r_err       <= !bus.f_sector_erase_end;
                        r_done      <= w_done_id;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done                = r_done;
    assign bus.err                 = r_err;
    assign bus.rdata               = r_rdata;
    assign bus.busy                = r_busy;
    assign bus.f_read_rq           = r_read_rq;
    assign bus.f_read_addr         = r_read_addr;
    assign bus.f_write_en_req      = r_wen_req;
    assign bus.f_write_req         = r_write_req;
    assign bus.f_write_page        = r_write_page;
    assign bus.f_write_data        = r_write_data;
    assign bus.f_sector_erase_req  = r_erase_req;
    assign bus.f_sector_erase_addr = r_erase_addr;
endmodule

// File: tb/tb_flash_op_scheduler.sv
// Bench for flash_op_scheduler: behavioural flash_sf3 model, two requesters and a done scoreboard.
// Expected completions are queued as each transaction is issued and popped on every done pulse.
module tb_flash_op_scheduler;
    localparam int TIMEOUT = 32;
    localparam int TO_W    = 6;
    localparam int STARVE  = 4;

    logic HCLK;
    logic HRST;
    flash_op_scheduler_if bus ();

    flash_op_scheduler #(
        .TIMEOUT      (TIMEOUT),
        .TO_W         (TO_W),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .HCLK (HCLK),
        .HRST (HRST),
        .bus  (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  done;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // flash model knobs and observations
    int          rd_lat = 20, wen_lat = 5, wr_lat = 7, er_lat = 9;
    logic        rd_noend = 1'b0, wr_noend = 1'b0, stray_end = 1'b0;
    int          rd_cnt = 0, wen_cnt = 0, wr_cnt = 0, er_cnt = 0;
    int          last_rd_len = 0;
    logic        prev_wen = 1'b0, chain_wr = 1'b0, chain_er = 1'b0, act_seen = 1'b0;
    logic [31:0] cap_wdata = 32'd0;
    logic [23:0] cap_page = 24'd0, cap_eaddr = 24'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : {8'hA5, a};
    endfunction

    // flash_sf3 behavioural model: end pulse on the Nth cycle a request is held
    initial begin
        forever begin
            @(negedge HCLK);
            if (bus.f_read_rq) rd_cnt++;
            else begin
                if (rd_cnt > 0) last_rd_len = rd_cnt;
                rd_cnt = 0;
            end
            if (bus.f_write_en_req) wen_cnt++; else wen_cnt = 0;
            if (bus.f_write_req) wr_cnt++; else wr_cnt = 0;
            if (bus.f_sector_erase_req) er_cnt++; else er_cnt = 0;
            bus.f_read_end         = bus.f_read_rq && !rd_noend && rd_cnt == rd_lat;
            bus.f_read_data_word   = flash_word(bus.f_read_addr);
            bus.f_write_en_end     = bus.f_write_en_req && wen_cnt == wen_lat;
            bus.f_write_end        = (bus.f_write_req && !wr_noend && wr_cnt == wr_lat) || stray_end;
            bus.f_sector_erase_end = bus.f_sector_erase_req && er_cnt == er_lat;
            if (bus.f_write_end && bus.f_write_req) begin
                cap_wdata = bus.f_write_data;
                cap_page  = bus.f_write_page;
            end
            if (bus.f_sector_erase_end) cap_eaddr = bus.f_sector_erase_addr;
            if (prev_wen && !bus.f_write_en_req) begin
                chain_wr = bus.f_write_req;
                chain_er = bus.f_sector_erase_req;
            end
            prev_wen = bus.f_write_en_req;
            if (bus.f_read_rq || bus.f_write_en_req || bus.f_write_req || bus.f_sector_erase_req)
                act_seen = 1'b1;
        end
    end

    // scoreboard: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (bus.done != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", {30'd0, bus.done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done", {30'd0, bus.done}, {30'd0, e.done});
                    check_eq("err", {31'd0, bus.err}, {31'd0, e.err});
                    check_eq("rdata", bus.rdata, e.rdata);
                    $display("[TB] done=%b err=%0b rdata=%08h (exp done=%b err=%0b rdata=%08h)",
                             bus.done, bus.err, bus.rdata, e.done, e.err, e.rdata);
                end
            end
        end
    end

    task automatic drive_port(input int port, input logic req, input logic [1:0] op,
                              input logic [23:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            bus.req0 = req; bus.op0 = op; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = req; bus.op1 = op; bus.addr1 = addr; bus.wdata1 = wd;
        end
    endtask

    task automatic do_op(input int port, input logic [1:0] op, input logic [23:0] addr,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        logic got;
        e.done  = (port == 1) ? 2'b10 : 2'b01;
        e.err   = exp_err;
        e.rdata = exp_rd;
        sb.push_back(e);
        $display("[TB] issue port%0d op=%b addr=%06h wdata=%08h", port, op, addr, wd);
        drive_port(port, 1'b1, op, addr, wd);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge HCLK);
            if (bus.done[port]) got = 1'b1;
        end
        drive_port(port, 1'b0, op, addr, wd);
        if (!got) check_eq("done_wait", 32'd0, 32'd1);
        @(negedge HCLK);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   order[10];
        int   ndone;
        logic seen;

        HRST = 1'b1;
        bus.req0 = 1'b0; bus.op0 = 2'b00; bus.addr0 = 24'd0; bus.wdata0 = 32'd0;
        bus.req1 = 1'b0; bus.op1 = 2'b00; bus.addr1 = 24'd0; bus.wdata1 = 32'd0;
        bus.f_read_end = 1'b0; bus.f_write_en_end = 1'b0; bus.f_write_end = 1'b0;
        bus.f_sector_erase_end = 1'b0; bus.f_read_data_word = 32'd0;
        repeat (3) @(negedge HCLK);
        check_eq("rst_done", {30'd0, bus.done}, 32'd0);
        check_eq("rst_err", {31'd0, bus.err}, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_reqs", {28'd0, bus.f_read_rq, bus.f_write_en_req, bus.f_write_req,
                              bus.f_sector_erase_req}, 32'd0);
        check_eq("rst_addrs", {8'd0, bus.f_read_addr | bus.f_write_page | bus.f_sector_erase_addr}, 32'd0);
        HRST = 1'b0;
        @(negedge HCLK);

        // port-0 read, 20-cycle flash read
        rd_lat = 20;
        do_op(0, 2'b00, 24'h000100, 32'd0, 1'b0, 32'hDEADBEEF);
        check_eq("rd_len", 32'(last_rd_len), 32'd20);
        check_eq("rd_addr", {8'd0, bus.f_read_addr}, 32'h000100);

        // port-1 program: WEN then PROG in the same edge
        do_op(1, 2'b01, 24'h001000, 32'h12345678, 1'b0, 32'hDEADBEEF);
        check_eq("wr_chain", {31'd0, chain_wr}, 32'd1);
        check_eq("wr_data", cap_wdata, 32'h12345678);
        check_eq("wr_page", {8'd0, cap_page}, 32'h001000);

        // port-0 sector erase
        do_op(0, 2'b10, 24'h020000, 32'd0, 1'b0, 32'hDEADBEEF);
        check_eq("er_chain", {31'd0, chain_er}, 32'd1);
        check_eq("er_addr", {8'd0, cap_eaddr}, 32'h020000);

        // starvation: both ports held, expect 0,0,0,0,1 twice
        rd_lat = 3;
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            e.done  = (order[i] == 1) ? 2'b10 : 2'b01;
            e.err   = 1'b0;
            e.rdata = flash_word((order[i] == 1) ? 24'h000500 : 24'h000400);
            sb.push_back(e);
        end
        $display("[TB] issue starvation burst: both ports reading continuously");
        drive_port(0, 1'b1, 2'b00, 24'h000400, 32'd0);
        drive_port(1, 1'b1, 2'b00, 24'h000500, 32'd0);
        ndone = 0;
        for (int i = 0; i < 400 && ndone < 10; i++) begin
            @(negedge HCLK);
            if (bus.done != 2'b00) ndone++;
        end
        drive_port(0, 1'b0, 2'b00, 24'h000400, 32'd0);
        drive_port(1, 1'b0, 2'b00, 24'h000500, 32'd0);
        check_eq("starve_count", 32'(ndone), 32'd10);
        @(negedge HCLK);

        // timeout on a read with no end pulse
        rd_noend = 1'b1;
        do_op(0, 2'b00, 24'h000700, 32'd0, 1'b1, 32'd0);
        check_eq("to_rd_len", 32'(last_rd_len), 32'(TIMEOUT));
        rd_noend = 1'b0;

        // end pulse on the very edge the step would time out is still a success
        rd_lat = TIMEOUT;
        do_op(1, 2'b00, 24'h000600, 32'd0, 1'b0, flash_word(24'h000600));
        check_eq("edge_rd_len", 32'(last_rd_len), 32'(TIMEOUT));

        // reserved op: error, rdata untouched, no flash activity
        act_seen = 1'b0;
        do_op(1, 2'b11, 24'h000800, 32'd0, 1'b1, flash_word(24'h000600));
        check_eq("rsv_activity", {31'd0, act_seen}, 32'd0);

        // stray end pulse in IDLE is ignored
        stray_end = 1'b1;
        repeat (2) @(negedge HCLK);
        stray_end = 1'b0;
        repeat (3) @(negedge HCLK);
        check_eq("stray_busy", {31'd0, bus.busy}, 32'd0);

        // reset in the middle of a program step
        wr_noend = 1'b1;
        $display("[TB] issue port0 program 002000, reset mid-PROG");
        drive_port(0, 1'b1, 2'b01, 24'h002000, 32'hCAFEF00D);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge HCLK);
            if (bus.f_write_req) seen = 1'b1;
        end
        check_eq("prog_reached", {31'd0, seen}, 32'd1);
        HRST = 1'b1;
        drive_port(0, 1'b0, 2'b01, 24'h002000, 32'hCAFEF00D);
        @(negedge HCLK);
        check_eq("rst_wr_req", {31'd0, bus.f_write_req}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        HRST = 1'b0;
        wr_noend = 1'b0;
        repeat (4) @(negedge HCLK);
        check_eq("rst_mid_rdata", bus.rdata, 32'd0);

        // normal read after the reset
        rd_lat = 20;
        do_op(0, 2'b00, 24'h000100, 32'd0, 1'b0, 32'hDEADBEEF);
        check_eq("post_rst_rd_len", 32'(last_rd_len), 32'd20);

        repeat (2) @(negedge HCLK);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
